johnson_sequence_checker: RTL and testbench

- Receive-side companion to the parameterised Johnson (twisted-ring) counter.
- Samples a width-bit Johnson code each qualified clock and decodes it to a binary step index.
- Flags illegal codes, tracks the expected successor, and declares lock after a run of correct steps.
- Counts sequence errors after lock. Used to monitor counter outputs in benches and in datapath self-checks.

---
 rtl/johnson_sequence_checker.sv | 146 ++++++++++++++
 tb/tb_johnson_sequence_checker.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/johnson_sequence_checker.sv
// Monitors a Johnson (twisted-ring) code stream: decodes each sample to a step index,
// flags illegal codes, acquires lock after a run of correct successors and counts violations.
module johnson_sequence_checker #(
    parameter int unsigned width    = 4,
    parameter int unsigned LOCK_LEN = 3,
    parameter int unsigned ERR_W    = 8,
    localparam int unsigned IW      = $clog2(2 * width)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic [width-1:0] i_code,
    output logic [IW-1:0]    o_index,
    output logic             o_index_valid,
    output logic             o_legal,
    output logic             o_locked,
    output logic             o_seq_err,
    output logic [ERR_W-1:0] o_err_count
);

    localparam int unsigned RW = $clog2(LOCK_LEN + 1);
    localparam logic [ERR_W-1:0] ErrMax = {ERR_W{1'b1}};

    typedef enum logic [1:0] {StIdle, StAcq, StLocked} state_e;

    state_e           r_state, w_state_d;
    logic [RW-1:0]    r_run, w_run_d;
    logic [IW-1:0]    r_index, w_index_d;
    logic             r_index_valid, w_index_valid_d;
    logic             r_legal, w_legal_d;
    logic             r_seq_err, w_seq_err_d;
    logic [ERR_W-1:0] r_err_count;

    logic [31:0]      w_pop;
    logic [31:0]      w_trans;
    logic             w_code_legal;
    logic [IW-1:0]    w_code_index;
    logic [IW-1:0]    w_succ;
    logic             w_correct;

    // Johnson codes are exactly the patterns with at most one adjacent-bit transition.
    always_comb begin
        w_pop   = '0;
        w_trans = '0;
        for (int i = 0; i < int'(width); i++) begin
            w_pop = w_pop + 32'(i_code[i]);
        end
        for (int i = 0; i < int'(width) - 1; i++) begin
            w_trans = w_trans + 32'(i_code[i] ^ i_code[i+1]);
        end
        w_code_legal = (w_trans <= 32'd1);
        w_code_index = i_code[width-1] ? IW'(32'(2 * width) - w_pop) : IW'(w_pop);
    end

    // r_index always equals the last legal index, so it doubles as the successor reference.
    assign w_succ    = (r_index == IW'(2 * width - 1)) ? '0 : r_index + IW'(1);
    assign w_correct = (w_code_index == w_succ);

    always_comb begin
        w_state_d       = r_state;
        w_run_d         = r_run;
        w_index_d       = r_index;
        w_index_valid_d = 1'b0;
        w_legal_d       = r_legal;
        w_seq_err_d     = 1'b0;

        if (i_valid) begin
            w_legal_d = w_code_legal;
            if (w_code_legal) begin
                w_index_d       = w_code_index;
                w_index_valid_d = 1'b1;
            end
        end

        unique case (r_state)
            StIdle: begin
                if (i_valid && w_code_legal) begin
                    w_state_d = StAcq;
                    w_run_d   = RW'(1);
                end
            end
            StAcq: begin
                if (i_valid) begin
                    if (!w_code_legal) begin
                        w_state_d = StIdle;
                        w_run_d   = '0;
                    end else if (w_correct) begin
                        w_run_d = r_run + RW'(1);
                        if (r_run + RW'(1) == RW'(LOCK_LEN)) begin
                            w_state_d = StLocked;
                        end
                    end else begin
                        w_run_d = RW'(1);
                    end
                end
            end
            StLocked: begin
                if (i_valid) begin
                    if (!w_code_legal) begin
                        w_seq_err_d = 1'b1;
                        w_state_d   = StIdle;
                        w_run_d     = '0;
                    end else if (!w_correct) begin
                        w_seq_err_d = 1'b1;
                        w_state_d   = StAcq;
                        w_run_d     = RW'(1);
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
                w_run_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_run         <= '0;
            r_index       <= '0;
            r_index_valid <= 1'b0;
            r_legal       <= 1'b0;
            r_seq_err     <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_state       <= w_state_d;
            r_run         <= w_run_d;
            r_index       <= w_index_d;
            r_index_valid <= w_index_valid_d;
            r_legal       <= w_legal_d;
            r_seq_err     <= w_seq_err_d;
            if (w_seq_err_d && (r_err_count != ErrMax)) begin
                r_err_count <= r_err_count + ERR_W'(1);
            end
        end
    end

    assign o_index       = r_index;
    assign o_index_valid = r_index_valid;
    assign o_legal       = r_legal;
    assign o_locked      = (r_state == StLocked);
    assign o_seq_err     = r_seq_err;
    assign o_err_count   = r_err_count;

endmodule

// File: tb/tb_johnson_sequence_checker.sv
// Directed bench: two checkers (ERR_W=8 and ERR_W=2) share one stimulus stream.
module tb_johnson_sequence_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid;
    logic [3:0] code;

    logic [2:0] d1_index, d2_index;
    logic       d1_iv, d1_legal, d1_locked, d1_seq;
    logic       d2_iv, d2_legal, d2_locked, d2_seq;
    logic [7:0] d1_err;
    logic [1:0] d2_err;

    int total = 0;
    int bad   = 0;

    johnson_sequence_checker #(.width(4), .LOCK_LEN(3), .ERR_W(8)) u_dut1 (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_valid       (valid),
        .i_code        (code),
        .o_index       (d1_index),
        .o_index_valid (d1_iv),
        .o_legal       (d1_legal),
        .o_locked      (d1_locked),
        .o_seq_err     (d1_seq),
        .o_err_count   (d1_err)
    );

    johnson_sequence_checker #(.width(4), .LOCK_LEN(3), .ERR_W(2)) u_dut2 (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_valid       (valid),
        .i_code        (code),
        .o_index       (d2_index),
        .o_index_valid (d2_iv),
        .o_legal       (d2_legal),
        .o_locked      (d2_locked),
        .o_seq_err     (d2_seq),
        .o_err_count   (d2_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one sample, let the edge take it, then look 1 time unit later.
    task automatic step(input logic r, input logic v, input logic [3:0] c);
        reset = r;
        valid = v;
        code  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic exp1(input string tag, input int idx, input int iv, input int lg,
                        input int lk, input int se, input int ec);
        chk({tag, "/d1.index"}, int'(d1_index), idx);
        chk({tag, "/d1.index_valid"}, int'(d1_iv), iv);
        chk({tag, "/d1.legal"}, int'(d1_legal), lg);
        chk({tag, "/d1.locked"}, int'(d1_locked), lk);
        chk({tag, "/d1.seq_err"}, int'(d1_seq), se);
        chk({tag, "/d1.err_count"}, int'(d1_err), ec);
    endtask

    task automatic exp2(input string tag, input int idx, input int iv, input int lg,
                        input int lk, input int se, input int ec);
        chk({tag, "/d2.index"}, int'(d2_index), idx);
        chk({tag, "/d2.index_valid"}, int'(d2_iv), iv);
        chk({tag, "/d2.legal"}, int'(d2_legal), lg);
        chk({tag, "/d2.locked"}, int'(d2_locked), lk);
        chk({tag, "/d2.seq_err"}, int'(d2_seq), se);
        chk({tag, "/d2.err_count"}, int'(d2_err), ec);
    endtask

    initial begin
        reset = 1'b1;
        valid = 1'b0;
        code  = 4'b0000;
        #1;
        step(1'b1, 1'b0, 4'b0000);
        step(1'b1, 1'b1, 4'b0011);
        exp1("reset", 0, 0, 0, 0, 0, 0);
        exp2("reset", 0, 0, 0, 0, 0, 0);

        // Acquire: 0000,0001,0011 -> locked on the third edge
        step(1'b0, 1'b1, 4'b0000); exp1("acq0", 0, 1, 1, 0, 0, 0);
        step(1'b0, 1'b1, 4'b0001); exp1("acq1", 1, 1, 1, 0, 0, 0);
        step(1'b0, 1'b1, 4'b0011); exp1("acq2", 2, 1, 1, 1, 0, 0);

        // Full cycle with wrap 7 -> 0
        step(1'b0, 1'b1, 4'b0111); exp1("run3", 3, 1, 1, 1, 0, 0);
        step(1'b0, 1'b1, 4'b1111); exp1("run4", 4, 1, 1, 1, 0, 0);
        step(1'b0, 1'b1, 4'b1110); exp1("run5", 5, 1, 1, 1, 0, 0);
        step(1'b0, 1'b1, 4'b1100); exp1("run6", 6, 1, 1, 1, 0, 0);
        step(1'b0, 1'b1, 4'b1000); exp1("run7", 7, 1, 1, 1, 0, 0);
        step(1'b0, 1'b1, 4'b0000); exp1("wrap", 0, 1, 1, 1, 0, 0);
        step(1'b0, 1'b1, 4'b0001);
        step(1'b0, 1'b1, 4'b0011);
        step(1'b0, 1'b1, 4'b0111); exp1("at3", 3, 1, 1, 1, 0, 0);

        // Skip 1111: wrong successor -> ACQ, then relock after two correct steps
        step(1'b0, 1'b1, 4'b1100); exp1("skip", 6, 1, 1, 0, 1, 1);
        step(1'b0, 1'b1, 4'b1000); exp1("reacq7", 7, 1, 1, 0, 0, 1);
        step(1'b0, 1'b1, 4'b0000); exp1("relock", 0, 1, 1, 1, 0, 1);

        // Illegal code while locked -> IDLE; 0000 enters ACQ, 0011 is a wrong step
        step(1'b0, 1'b1, 4'b0101); exp1("illegal", 0, 0, 0, 0, 1, 2);
        step(1'b0, 1'b1, 4'b0000); exp1("idle2acq", 0, 1, 1, 0, 0, 2);
        step(1'b0, 1'b1, 4'b0011); exp1("acqwrong", 2, 1, 1, 0, 0, 2);
        step(1'b0, 1'b1, 4'b0111); exp1("acqrun2", 3, 1, 1, 0, 0, 2);
        step(1'b0, 1'b1, 4'b1111); exp1("acqlock", 4, 1, 1, 1, 0, 2);

        // Valid gap: everything holds, pulses stay low, garbage code ignored
        step(1'b0, 1'b0, 4'b0101); exp1("gap1", 4, 0, 1, 1, 0, 2);
        step(1'b0, 1'b0, 4'b0000); exp1("gap2", 4, 0, 1, 1, 0, 2);
        step(1'b0, 1'b0, 4'b1010); exp1("gap3", 4, 0, 1, 1, 0, 2);
        step(1'b0, 1'b1, 4'b1110); exp1("resume", 5, 1, 1, 1, 0, 2);

        // Saturation on the ERR_W=2 instance after a fresh reset
        step(1'b1, 1'b1, 4'b0000); exp2("rst2", 0, 0, 0, 0, 0, 0);
        step(1'b0, 1'b1, 4'b0000);
        step(1'b0, 1'b1, 4'b0001);
        step(1'b0, 1'b1, 4'b0011); exp2("sat.lock", 2, 1, 1, 1, 0, 0);
        step(1'b0, 1'b1, 4'b1110); exp2("sat.v1", 5, 1, 1, 0, 1, 1);
        step(1'b0, 1'b1, 4'b1100); exp2("sat.pulse1", 6, 1, 1, 0, 0, 1);
        step(1'b0, 1'b1, 4'b1000);
        step(1'b0, 1'b1, 4'b0011); exp2("sat.v2", 2, 1, 1, 0, 1, 2);
        step(1'b0, 1'b1, 4'b0111);
        step(1'b0, 1'b1, 4'b1111);
        step(1'b0, 1'b1, 4'b1000); exp2("sat.v3", 7, 1, 1, 0, 1, 3);
        step(1'b0, 1'b1, 4'b0000);
        step(1'b0, 1'b1, 4'b0001);
        step(1'b0, 1'b1, 4'b1111); exp2("sat.v4", 4, 1, 1, 0, 1, 3);
        step(1'b0, 1'b1, 4'b1110);
        step(1'b0, 1'b1, 4'b1100);
        step(1'b0, 1'b1, 4'b0001); exp2("sat.v5", 1, 1, 1, 0, 1, 3);
        exp1("wide.v5", 1, 1, 1, 0, 1, 5);

        // Reset during a seq_err pulse and with valid high
        step(1'b1, 1'b1, 4'b0011);
        exp1("midrst", 0, 0, 0, 0, 0, 0);
        exp2("midrst", 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
